// File: rtl/conv_pkg.sv
// conv_pkg: state encoding, accumulator width and parameter legality check shared by the convolution core.
package conv_pkg;
   typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, FIN} state_e;
   function automatic int acc_width(int data_w, int addr_w_x);
      return 2 * data_w + addr_w_x;
   endfunction
   function automatic bit widths_ok(int awx, int awy, int awz);
      return awz >= ((awx > awy) ? awx : awy) + 1;
   endfunction
endpackage

// File: rtl/conv_core_param_if.sv
// conv_core_param_if: AIP-side control plus X/Y read and Z write memory ports of the convolution core.
interface conv_core_param_if #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W_X = 5,
   parameter int ADDR_W_Y = 5,
   parameter int ADDR_W_Z = 6,
   parameter int Z_W      = 16
);
   logic                start;
   logic [ADDR_W_X-1:0] sizeX;
   logic [ADDR_W_Y-1:0] sizeY;
   logic [ADDR_W_X-1:0] memX_addr;
   logic [DATA_W-1:0]   dataX;
   logic [ADDR_W_Y-1:0] memY_addr;
   logic [DATA_W-1:0]   dataY;
   logic [ADDR_W_Z-1:0] memZ_addr;
   logic [Z_W-1:0]      dataZ;
   logic                writeZ;
   logic                busy;
   logic                done;
   modport master (
      input  start, sizeX, sizeY, dataX, dataY,
      output memX_addr, memY_addr, memZ_addr, dataZ, writeZ, busy, done
   );
   modport slave (
      output start, sizeX, sizeY, dataX, dataY,
      input  memX_addr, memY_addr, memZ_addr, dataZ, writeZ, busy, done
   );
endinterface

// File: rtl/conv_mac.sv
// conv_mac: registered unsigned multiply-accumulate with synchronous clear and enable.
module conv_mac #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 21
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [ACC_W-1:0]  acc_d_o
);
   logic [2*DATA_W-1:0] prod;
   logic [ACC_W-1:0]    acc_q;
   assign prod    = (2*DATA_W)'(a_i) * (2*DATA_W)'(b_i);
   // Next value is exported so the writer can register the finished sum in the same edge.
   assign acc_d_o = clr_i ? '0 : en_i ? acc_q + ACC_W'(prod) : acc_q;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) acc_q <= '0;
      else       acc_q <= acc_d_o;
endmodule

// File: rtl/conv_core_param.sv
// conv_core_param: full linear convolution Z = X * Y with run-time lengths.
// CONV_SATURATE_EN: clamp dataZ to all-ones when the sum exceeds Z_W bits, else truncate.
module conv_core_param
   import conv_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int ADDR_W_X = 5,
   parameter int ADDR_W_Y = 5,
   parameter int ADDR_W_Z = 6,
   parameter int Z_W      = 16
) (
   input logic                clk,
   input logic                rstn,
   conv_core_param_if.master  bus
);
   localparam int ACC_W = acc_width(DATA_W, ADDR_W_X);
   localparam int NW    = ADDR_W_Z;
   if (!widths_ok(ADDR_W_X, ADDR_W_Y, ADDR_W_Z)) begin : g_width_chk
      $error("ADDR_W_Z must be at least max(ADDR_W_X, ADDR_W_Y)+1");
   end
   state_e              state_q;
   logic [ADDR_W_X-1:0] sx_q, k_q, kmax_q;
   logic [ADDR_W_Y-1:0] sy_q, y_q;
   logic [NW-1:0]       n_q, n_nx, sx_w, sy_w, last_n, kmin_nx, kmax_nx, za_q;
   logic                vld_q, wr_q, busy_q, done_q, clr;
   logic [Z_W-1:0]      dz_q, dz_d;
   logic [ACC_W-1:0]    acc_d;
   assign sx_w    = NW'(sx_q);
   assign sy_w    = NW'(sy_q);
   assign n_nx    = n_q + NW'(1);
   assign last_n  = sx_w + sy_w - NW'(2);
   assign kmin_nx = (n_nx >= sy_w) ? n_nx - sy_w + NW'(1) : '0;
   assign kmax_nx = (n_nx < sx_w) ? n_nx : sx_w - NW'(1);
   assign clr     = (state_q == WRITE) || (state_q == IDLE && bus.start);
`ifdef CONV_SATURATE_EN
   assign dz_d = (|(acc_d >> Z_W)) ? '1 : acc_d[Z_W-1:0];
`else
   assign dz_d = acc_d[Z_W-1:0];
`endif
   // vld_q marks that the memory data now present belongs to an address issued last cycle.
   conv_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
      .clk(clk), .rstn(rstn), .clr_i(clr), .en_i(vld_q),
      .a_i(bus.dataX), .b_i(bus.dataY), .acc_d_o(acc_d)
   );
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state_q <= IDLE;
         {sx_q, k_q, kmax_q, sy_q, y_q, n_q, za_q, dz_q} <= '0;
         {vld_q, wr_q, busy_q, done_q} <= '0;
      end else begin
         vld_q <= (state_q == ISSUE);
         case (state_q)
            IDLE: if (bus.start) begin
               sx_q <= bus.sizeX;
               sy_q <= bus.sizeY;
               n_q  <= '0;
               if (bus.sizeX == '0 || bus.sizeY == '0) begin
                  state_q <= FIN;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= ISSUE;
                  busy_q  <= 1'b1;
                  k_q     <= '0;
                  y_q     <= '0;
                  kmax_q  <= '0;
               end
            end
            ISSUE: if (k_q == kmax_q) state_q <= DRAIN;
            else begin
               k_q <= k_q + 1'b1;
               y_q <= y_q - 1'b1;
            end
            DRAIN: begin
               state_q <= WRITE;
               wr_q    <= 1'b1;
               za_q    <= n_q;
               dz_q    <= dz_d;
            end
            WRITE: begin
               wr_q <= 1'b0;
               if (n_q == last_n) begin
                  state_q <= FIN;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= ISSUE;
                  n_q     <= n_nx;
                  k_q     <= ADDR_W_X'(kmin_nx);
                  y_q     <= ADDR_W_Y'(n_nx - kmin_nx);
                  kmax_q  <= ADDR_W_X'(kmax_nx);
               end
            end
            default: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   assign bus.memX_addr = k_q;
   assign bus.memY_addr = y_q;
   assign bus.memZ_addr = za_q;
   assign bus.dataZ     = dz_q;
   assign bus.writeZ    = wr_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
endmodule

// File: tb/tb_conv_core_param.sv
// tb_conv_core_param: scoreboard bench for conv_core_param with behavioural X/Y memories.
module tb_conv_core_param;
   localparam int DW = 8, AX = 5, AY = 5, AZ = 6, ZW = 16;
   typedef struct {int addr; longint data;} wr_t;
   logic clk = 1'b0, rstn = 1'b0;
   always #5 clk = ~clk;
   conv_core_param_if #(.DATA_W(DW), .ADDR_W_X(AX), .ADDR_W_Y(AY), .ADDR_W_Z(AZ), .Z_W(ZW)) bus ();
   conv_core_param #(.DATA_W(DW), .ADDR_W_X(AX), .ADDR_W_Y(AY), .ADDR_W_Z(AZ), .Z_W(ZW)) dut (
      .clk(clk), .rstn(rstn), .bus(bus)
   );
   logic [DW-1:0] memx [32];
   logic [DW-1:0] memy [32];
   logic [ZW-1:0] zmem [64];
   wr_t sbq [$];
   wr_t e;
   int n_chk = 0, n_fail = 0, done_cnt = 0;
   always @(posedge clk) begin
      bus.dataX <= memx[bus.memX_addr];
      bus.dataY <= memy[bus.memY_addr];
   end
   task automatic check(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   function automatic longint zval(longint acc);
`ifdef CONV_SATURATE_EN
      return (acc >= (64'd1 << ZW)) ? (64'd1 << ZW) - 1 : acc;
`else
      return acc % (64'd1 << ZW);
`endif
   endfunction
   // Direct double sum over all index pairs; returns the expected done cycle after start.
   function automatic int model(int sx, int sy);
      int cyc = 1;
      if (sx == 0 || sy == 0) return 1;
      for (int n = 0; n <= sx + sy - 2; n++) begin
         longint acc = 0;
         int t = 0;
         for (int k = 0; k < sx; k++)
            if (n - k >= 0 && n - k < sy) begin
               acc += longint'(memx[k]) * longint'(memy[n-k]);
               t++;
            end
         sbq.push_back('{n, zval(acc)});
         cyc += t + 2;
      end
      return cyc;
   endfunction
   always @(negedge clk) if (rstn) begin
      if (bus.writeZ) begin
         if (sbq.size() == 0) check("extra_wr", 1, 0);
         else begin
            e = sbq.pop_front();
            check("z_addr", bus.memZ_addr, e.addr);
            check("z_data", bus.dataZ, e.data);
         end
         zmem[bus.memZ_addr] = bus.dataZ;
      end
      if (bus.done) done_cnt++;
   end
   function automatic longint outs();
      return {bus.writeZ, bus.done, bus.busy, bus.memX_addr, bus.memY_addr, bus.memZ_addr, bus.dataZ};
   endfunction
   task automatic run_job(input int sx, input int sy, input bit dbl, input int rst_at);
      int exp, seen, busy_bad, d0;
      exp = model(sx, sy);
      seen = -1;
      busy_bad = 0;
      d0 = done_cnt;
      @(negedge clk);
      bus.start = 1'b1;
      bus.sizeX = AX'(sx);
      bus.sizeY = AY'(sy);
      for (int c = 1; c <= 4000; c++) begin
         @(negedge clk);
         bus.start = dbl && c == 3;
         bus.sizeX = AX'($urandom_range(1, 31));
         bus.sizeY = AY'($urandom_range(1, 31));
         if (rst_at == c) begin
            rstn = 1'b0;
            #1;
            check("rst_outs", outs(), 0);
            sbq.delete();
            return;
         end
         if (bus.done) begin
            seen = c;
            break;
         end
         if (bus.busy == (sx == 0 || sy == 0)) busy_bad++;
      end
      check("done_cyc", seen, exp);
      check("busy_at_done", bus.busy, 0);
      check("busy_span", busy_bad, 0);
      check("pending_wr", sbq.size(), 0);
      @(negedge clk);
      check("done_pulse", bus.done, 0);
      check("done_cnt", done_cnt - d0, 1);
   endtask
   initial begin
      bus.start = 1'b0;
      bus.sizeX = '0;
      bus.sizeY = '0;
      for (int i = 0; i < 32; i++) begin
         memx[i] = '0;
         memy[i] = '0;
      end
      repeat (3) @(negedge clk);
      check("reset_outs", outs(), 0);
      rstn = 1'b1;
      @(negedge clk);
      check("idle_outs", outs(), 0);
      memx[0] = 8'd1; memx[1] = 8'd2; memx[2] = 8'd3;
      memy[0] = 8'd1; memy[1] = 8'd1;
      run_job(3, 2, 1'b0, 0);
      check("z0", zmem[0], 1);
      check("z1", zmem[1], 3);
      check("z2", zmem[2], 5);
      check("z3", zmem[3], 3);
      memx[0] = 8'd255; memy[0] = 8'd255;
      run_job(1, 1, 1'b0, 0);
      check("z_1x1", zmem[0], 65025);
      run_job(0, 5, 1'b0, 0);
      for (int i = 0; i < 4; i++) begin
         memx[i] = 8'd255;
         memy[i] = 8'd255;
      end
      run_job(4, 4, 1'b0, 0);
`ifdef CONV_SATURATE_EN
      check("z3_sat", zmem[3], 16'hFFFF);
`else
      check("z3_trunc", zmem[3], 16'hF804);
`endif
      memx[0] = 8'd1; memx[1] = 8'd2; memx[2] = 8'd3;
      memy[0] = 8'd1; memy[1] = 8'd1;
      run_job(3, 2, 1'b1, 0);
      begin
         int d0;
         d0 = done_cnt;
         run_job(3, 2, 1'b0, 9);
         repeat (2) @(negedge clk);
         check("rst_hold_outs", outs(), 0);
         rstn = 1'b1;
         repeat (6) @(negedge clk);
         check("no_done_after_rst", done_cnt - d0, 0);
      end
      run_job(3, 2, 1'b0, 0);
      check("rerun_z2", zmem[2], 5);
      for (int j = 0; j < 3; j++) begin
         for (int i = 0; i < 32; i++) begin
            memx[i] = DW'($urandom);
            memy[i] = DW'($urandom);
         end
         run_job(j == 0 ? 31 : $urandom_range(1, 31), j == 0 ? 31 : $urandom_range(1, 31), 1'b0, 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
